uart_rx: RTL and testbench

//  Serial UART receiver: 8N1 line in, byte stream out on a valid/ready handshake.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions (state encoding, defaults, data width)
//
// Purpose: common constants and the receive/transmit FSM state type for the UART blocks.
// Ports: none (package).
package uart_pkg;

  localparam int DEFAULT_CYCLES_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam int DATA_W                 = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_DELIVER = 3'd5,
    ST_BREAK   = 3'd6
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous input
//
// Purpose: bring an asynchronous 1-bit signal into the clk domain.
// Ports:
//   clk        in  system clock
//   m_aresetn  in  asynchronous active-low reset (both flops load RESET_VAL)
//   d          in  asynchronous input
//   q          out synchronised output
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic m_aresetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 (optionally 8E1) UART receiver with valid/ready byte output
//
// Purpose: samples uart_rxd mid-bit with a cycle counter, delivers bytes on a
//   valid/ready handshake, reports framing errors and overruns.
// Optional feature: define UART_RX_PARITY_EN for an even parity bit after D7
//   (mismatch pulses rx_perr in the delivery cycle; without it rx_perr is 0).
// Ports:
//   clk        in  system clock
//   m_aresetn  in  asynchronous active-low reset
//   uart_rxd   in  asynchronous serial line, idle high
//   rx_valid   out rx_data holds an unconsumed byte
//   rx_data    out received byte (LSB first on the line)
//   rx_ready   in  consumer accepts the byte when rx_valid && rx_ready
//   rx_ferr    out one-cycle pulse: stop bit sampled low
//   rx_perr    out one-cycle pulse: parity mismatch
//   rx_overrun out sticky: a byte completed while the previous one was unconsumed
module uart_rx
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
  parameter int STOP_BITS      = 1
) (
  input  logic              clk,
  input  logic              m_aresetn,
  input  logic              uart_rxd,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              rx_ferr,
  output logic              rx_perr,
  output logic              rx_overrun
);

  localparam int            CW       = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CYCLES_PER_BIT / 2 - 1);

  logic              rxs;
  uart_state_t       state;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic              stop_idx;
  logic [DATA_W-1:0] shreg;
  logic              cnt_last;
  logic              take;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk       (clk),
    .m_aresetn (m_aresetn),
    .d         (uart_rxd),
    .q         (rxs)
  );

  assign cnt_last = (cnt == CNT_LAST);
  assign take     = rx_valid && rx_ready;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic perr_q;
  assign rx_perr = perr_q;
`else
  assign rx_perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_ferr    <= 1'b0;
      rx_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      rx_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      // Counter free-runs; every state transition below reloads it to 0.
      cnt <= cnt + CW'(1);
      if (take) rx_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rxs) state <= ST_START;
        end

        ST_START: begin
          if (cnt == CNT_MID) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A start bit that is gone by mid-bit is line noise; drop it silently.
            state   <= rxs ? ST_IDLE : ST_DATA;
          end
        end

        ST_DATA: begin
          if (cnt_last) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[DATA_W-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              stop_idx <= 1'b0;
`ifdef UART_RX_PARITY_EN
              state    <= ST_PARITY;
`else
              state    <= ST_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_last) begin
            cnt     <= '0;
            par_bit <= rxs;
            state   <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (cnt_last) begin
            cnt <= '0;
            if (!rxs) begin
              rx_ferr <= 1'b1;
              state   <= ST_BREAK;
            end else if (STOP_BITS == 1 || stop_idx) begin
              state <= ST_DELIVER;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end

        ST_DELIVER: begin
          cnt      <= '0;
          rx_valid <= 1'b1;
          rx_data  <= shreg;
          // Same-cycle handshake frees the slot, so only an unconsumed byte overruns.
          if (rx_valid && !rx_ready) rx_overrun <= 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_q   <= (^shreg) ^ par_bit;
`endif
          state    <= ST_IDLE;
        end

        ST_BREAK: begin
          cnt <= '0;
          if (rxs) state <= ST_IDLE;
        end

        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx (CYCLES_PER_BIT=16, STOP_BITS=1)
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       m_aresetn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;
  logic       rx_perr;
  logic       rx_overrun;

  uart_rx #(.CYCLES_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk        (clk),
    .m_aresetn  (m_aresetn),
    .uart_rxd   (uart_rxd),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rx_ferr    (rx_ferr),
    .rx_perr    (rx_perr),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         checks = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         valid_cycles = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         rise_cyc = 0;
  logic       prev_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples just after the negedge, when this cycle's inputs are settled.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (m_aresetn) begin
        if (rx_valid) valid_cycles++;
        if (rx_valid && !prev_v) rise_cyc = cyc;
        if (rx_ferr) ferr_cnt++;
        if (rx_perr) perr_cnt++;
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_byte: got %0h expected none", rx_data);
          end else begin
            chk("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
          end
        end
      end
      prev_v = rx_valid;
    end
  end

  task automatic send_bit(input logic b);
    uart_rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    uart_rxd = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
    uart_rxd = 1'b1;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int vc;
    int fc;
    int pc;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_rx_data", {24'h0, rx_data}, 32'h0);
    chk("reset_rx_ferr", {31'h0, rx_ferr}, 32'h0);
    chk("reset_rx_perr", {31'h0, rx_perr}, 32'h0);
    chk("reset_rx_overrun", {31'h0, rx_overrun}, 32'h0);
    m_aresetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", 32'(dut.state), 32'(ST_IDLE));

    // Frame 0xA5, rx_ready high: valid for one cycle, 154..156 cycles after the start edge
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    vc = valid_cycles;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (5) @(negedge clk);
    chk("a5_latency_in_window", 32'((rise_cyc - t0 >= 154) && (rise_cyc - t0 <= 156)), 32'h1);
    chk("a5_valid_cycles", 32'(valid_cycles - vc), 32'h1);

    // 5-cycle low glitch: nothing reported, back in IDLE
    vc = valid_cycles;
    fc = ferr_cnt;
    uart_rxd = 1'b0;
    repeat (5) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_valid", 32'(valid_cycles - vc), 32'h0);
    chk("glitch_no_ferr", 32'(ferr_cnt - fc), 32'h0);
    chk("glitch_idle", 32'(dut.state), 32'(ST_IDLE));

    // 0x3C with stop bit low: one ferr, no byte; then 0x55 received normally
    vc = valid_cycles;
    fc = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_one_pulse", 32'(ferr_cnt - fc), 32'h1);
    chk("ferr_no_valid", 32'(valid_cycles - vc), 32'h0);
    chk("ferr_idle_after_high", 32'(dut.state), 32'(ST_IDLE));
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    repeat (10) @(negedge clk);

    // Overrun: 0x11 then 0x22 without consuming
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (10) @(negedge clk);
    chk("ovr_rx_valid", {31'h0, rx_valid}, 32'h1);
    chk("ovr_rx_data", {24'h0, rx_data}, 32'h22);
    chk("ovr_rx_overrun", {31'h0, rx_overrun}, 32'h1);
    exp_q.push_back(8'h22);
    rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("ovr_valid_dropped", {31'h0, rx_valid}, 32'h0);
    chk("ovr_overrun_sticky", {31'h0, rx_overrun}, 32'h1);

    // Reset during D4 of 0xFF, then 0x81 is the only byte delivered
    fc = ferr_cnt;
    send_bit(1'b0);
    uart_rxd = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    m_aresetn = 1'b0;
    repeat (3) @(negedge clk);
    m_aresetn = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst_mid_no_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_mid_overrun_clear", {31'h0, rx_overrun}, 32'h0);
    chk("rst_mid_idle", 32'(dut.state), 32'(ST_IDLE));
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (10) @(negedge clk);
    chk("rst_81_no_ferr", 32'(ferr_cnt - fc), 32'h0);
    chk("rst_81_no_overrun", {31'h0, rx_overrun}, 32'h0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: even parity bit is 1, so a 0 is a mismatch
    pc = perr_cnt;
    exp_q.push_back(8'h07);
    send_frame_par(8'h07, 1'b0);
    repeat (10) @(negedge clk);
    chk("par_bad_perr", 32'(perr_cnt - pc), 32'h1);
    pc = perr_cnt;
    exp_q.push_back(8'h07);
    send_frame_par(8'h07, 1'b1);
    repeat (10) @(negedge clk);
    chk("par_good_perr", 32'(perr_cnt - pc), 32'h0);
`else
    pc = perr_cnt;
    chk("perr_never", 32'(pc), 32'h0);
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
